// File: rtl/pid_pkg.sv
// Shared constants, state/config encodings and overflow helper for the
// time-multiplexed PI channel scheduler.
package pid_pkg;

  localparam int N = 32;
  localparam int Q = 18;
  localparam logic [N-1:0] FP_ONE = 32'h0004_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SUM  = 3'd1,
    KI   = 3'd2,
    ACC  = 3'd3,
    OUT  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CFG_KP  = 2'd0,
    CFG_KI  = 2'd1,
    CFG_CLR = 2'd2,
    CFG_NOP = 2'd3
  } cfg_sel_e;

  // Two's-complement add overflow from operand and result sign bits.
  function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

endpackage

// File: rtl/qmult.sv
// Signed fixed-point multiplier: returns the Q-aligned N-bit slice of the full
// product and flags when the discarded high bits are not a pure sign extension.
module qmult #(
  parameter int N = 32,
  parameter int Q = 18
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] q,
  output logic         ovf
);

  logic [2*N-1:0] a_ext_s;
  logic [2*N-1:0] b_ext_s;
  logic [2*N-1:0] prod_s;
  logic [N-Q:0]   hi_s;
  logic           unused_low_s;

  // Low 2N bits of the sign-extended product equal the exact signed product.
  assign a_ext_s      = {{N{a[N-1]}}, a};
  assign b_ext_s      = {{N{b[N-1]}}, b};
  assign prod_s       = a_ext_s * b_ext_s;
  assign q            = prod_s[N-1+Q:Q];
  assign hi_s         = prod_s[2*N-1:N-1+Q];
  assign ovf          = ~((&hi_s) | (~|hi_s));
  assign unused_low_s = ^prod_s[Q-1:0];

endmodule

// File: rtl/pi_channel_scheduler.sv
// Round-robin PI controller sharing one multiplier and one adder across CH
// channels; each sample walks IDLE->SUM->KI->ACC->OUT.
module pi_channel_scheduler #(
  parameter int N = pid_pkg::N,
  parameter int Q = pid_pkg::Q,
  parameter int CH = 4,
  parameter logic [N-1:0] KP_INIT = pid_pkg::FP_ONE,
  parameter logic [N-1:0] KI_INIT = {N{1'b0}},
  localparam int CW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH-1:0]   req,
  input  logic [CH*N-1:0] req_data,
  output logic [CH-1:0]   ack,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [1:0]      cfg_sel,
  input  logic [N-1:0]    cfg_data,
  output logic            out_valid,
  output logic [CW-1:0]   out_ch,
  output logic [N-1:0]    out_data,
  output logic            out_of,
  output logic            busy
);

  import pid_pkg::*;

  state_e        state_r;
  state_e        state_next_s;

  logic [CW-1:0] ptr_r;
  logic [CW-1:0] ch_r;
  logic [CW-1:0] grant_ch_s;
  logic [CW-1:0] idx_s;
  logic          grant_s;
  logic          cfg_ok_s;

  logic [N-1:0]  kp_r      [CH];
  logic [N-1:0]  ki_r      [CH];
  logic [N-1:0]  prev_in_r [CH];
  logic [N-1:0]  prev_ki_r [CH];

  logic [N-1:0]  x_r;
  logic [N-1:0]  kp_lat_r;
  logic [N-1:0]  ki_lat_r;
  logic [N-1:0]  xp_r;
  logic [N-1:0]  ip_r;
  logic [N-1:0]  s_r;
  logic [N-1:0]  kp_term_r;
  logic [N-1:0]  ki_term_r;
  logic [N-1:0]  i_new_r;
  logic          of_acc_r;

  logic [N-1:0]  add_a_s;
  logic [N-1:0]  add_b_s;
  logic [N-1:0]  add_sum_s;
  logic          add_ovf_s;
  logic [N-1:0]  mul_a_s;
  logic [N-1:0]  mul_b_s;
  logic [N-1:0]  mul_q_s;
  logic          mul_ovf_s;

  logic [CH-1:0] ack_r;
  logic          out_valid_r;
  logic [CW-1:0] out_ch_r;
  logic [N-1:0]  out_data_r;
  logic          out_of_r;
  logic          busy_r;

  assign cfg_ok_s = int'(cfg_ch) < CH;

  // Round-robin search for the first pending request at or after ptr.
  always_comb begin
    grant_s    = 1'b0;
    grant_ch_s = {CW{1'b0}};
    idx_s      = {CW{1'b0}};
    for (int i = 0; i < CH; i++) begin
      idx_s = CW'((int'(ptr_r) + i) % CH);
      if (!grant_s && req[idx_s]) begin
        grant_s    = 1'b1;
        grant_ch_s = idx_s;
      end else begin
        grant_s    = grant_s;
      end
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_next_s = SUM;
        end else begin
          state_next_s = IDLE;
        end
      end
      SUM:     state_next_s = KI;
      KI:      state_next_s = ACC;
      ACC:     state_next_s = OUT;
      OUT:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand steering for the shared adder and multiplier.
  always_comb begin
    add_a_s = {N{1'b0}};
    add_b_s = {N{1'b0}};
    mul_a_s = {N{1'b0}};
    mul_b_s = {N{1'b0}};
    case (state_r)
      SUM: begin
        add_a_s = x_r;
        add_b_s = xp_r;
        mul_a_s = x_r;
        mul_b_s = kp_lat_r;
      end
      KI: begin
        mul_a_s = s_r;
        mul_b_s = ki_lat_r;
      end
      ACC: begin
        add_a_s = ki_term_r;
        add_b_s = ip_r;
      end
      OUT: begin
        add_a_s = kp_term_r;
        add_b_s = i_new_r;
      end
      default: begin
        add_a_s = {N{1'b0}};
        add_b_s = {N{1'b0}};
      end
    endcase
  end

  assign add_sum_s = add_a_s + add_b_s;
  assign add_ovf_s = add_ovf(add_a_s[N-1], add_b_s[N-1], add_sum_s[N-1]);

  qmult #(
    .N (N),
    .Q (Q)
  ) u_qmult (
    .a   (mul_a_s),
    .b   (mul_b_s),
    .q   (mul_q_s),
    .ovf (mul_ovf_s)
  );

  // Grant, operand latching, pipeline registers and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r       <= {CW{1'b0}};
      ch_r        <= {CW{1'b0}};
      x_r         <= {N{1'b0}};
      kp_lat_r    <= {N{1'b0}};
      ki_lat_r    <= {N{1'b0}};
      xp_r        <= {N{1'b0}};
      ip_r        <= {N{1'b0}};
      s_r         <= {N{1'b0}};
      kp_term_r   <= {N{1'b0}};
      ki_term_r   <= {N{1'b0}};
      i_new_r     <= {N{1'b0}};
      of_acc_r    <= 1'b0;
      ack_r       <= {CH{1'b0}};
      out_valid_r <= 1'b0;
      out_ch_r    <= {CW{1'b0}};
      out_data_r  <= {N{1'b0}};
      out_of_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      ack_r       <= {CH{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            ch_r              <= grant_ch_s;
            x_r               <= req_data[grant_ch_s*N +: N];
            kp_lat_r          <= kp_r[grant_ch_s];
            ki_lat_r          <= ki_r[grant_ch_s];
            xp_r              <= prev_in_r[grant_ch_s];
            ip_r              <= prev_ki_r[grant_ch_s];
            of_acc_r          <= 1'b0;
            ack_r[grant_ch_s] <= 1'b1;
            if (grant_ch_s == CW'(CH - 1)) begin
              ptr_r <= {CW{1'b0}};
            end else begin
              ptr_r <= grant_ch_s + CW'(1);
            end
          end
        end
        SUM: begin
          s_r       <= add_sum_s;
          kp_term_r <= mul_q_s;
          of_acc_r  <= of_acc_r | add_ovf_s | mul_ovf_s;
        end
        KI: begin
          ki_term_r <= mul_q_s;
          of_acc_r  <= of_acc_r | mul_ovf_s;
        end
        ACC: begin
          i_new_r  <= add_sum_s;
          of_acc_r <= of_acc_r | add_ovf_s;
        end
        OUT: begin
          out_valid_r <= 1'b1;
          out_ch_r    <= ch_r;
          out_data_r  <= add_sum_s;
          out_of_r    <= of_acc_r | add_ovf_s;
        end
        default: begin
          ack_r <= {CH{1'b0}};
        end
      endcase
    end
  end

  // Per-channel gains and history; a clear issued on the write-back edge wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        kp_r[i]      <= KP_INIT;
        ki_r[i]      <= KI_INIT;
        prev_in_r[i] <= {N{1'b0}};
        prev_ki_r[i] <= {N{1'b0}};
      end
    end else begin
      if (state_r == OUT) begin
        prev_in_r[ch_r] <= x_r;
        prev_ki_r[ch_r] <= i_new_r;
      end
      if (cfg_we && cfg_ok_s) begin
        case (cfg_sel)
          CFG_KP:  kp_r[cfg_ch] <= cfg_data;
          CFG_KI:  ki_r[cfg_ch] <= cfg_data;
          CFG_CLR: begin
            prev_in_r[cfg_ch] <= {N{1'b0}};
            prev_ki_r[cfg_ch] <= {N{1'b0}};
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign ack       = ack_r;
  assign out_valid = out_valid_r;
  assign out_ch    = out_ch_r;
  assign out_data  = out_data_r;
  assign out_of    = out_of_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_pi_channel_scheduler.sv
// Self-checking bench: a cycle-level reference model of the scheduler compared
// every cycle, plus directed samples with hand-computed literal results.
module tb_pi_channel_scheduler;

  localparam int N  = 32;
  localparam int Q  = 18;
  localparam int CH = 4;
  localparam int CW = 2;
  localparam logic [N-1:0] KP_INIT = 32'h0004_0000;
  localparam logic [N-1:0] KI_INIT = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   req;
  logic [CH*N-1:0] req_data;
  logic [CH-1:0]   ack;
  logic            cfg_we;
  logic [CW-1:0]   cfg_ch;
  logic [1:0]      cfg_sel;
  logic [N-1:0]    cfg_data;
  logic            out_valid;
  logic [CW-1:0]   out_ch;
  logic [N-1:0]    out_data;
  logic            out_of;
  logic            busy;

  pi_channel_scheduler #(
    .N(N), .Q(Q), .CH(CH), .KP_INIT(KP_INIT), .KI_INIT(KI_INIT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
    .out_of(out_of), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sx(input logic [N-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic bit fits_n(input longint v);
    return (v <= 64'sd2147483647) && (v >= -64'sd2147483648);
  endfunction

  function automatic void pi_eval(input logic [N-1:0] x, input logic [N-1:0] kp,
                                  input logic [N-1:0] ki, input logic [N-1:0] xp,
                                  input logic [N-1:0] ip, output logic [N-1:0] y,
                                  output logic [N-1:0] inew, output logic of);
    longint lim = 64'sd1 << (N - 1 + Q);
    longint s_f, p1, p2, i_f, y_f;
    logic [N-1:0] s, kpt, kit;
    of   = 1'b0;
    s_f  = sx(x) + sx(xp);
    of   = of | !fits_n(s_f);
    s    = s_f[N-1:0];
    p1   = sx(x) * sx(kp);
    of   = of | (p1 >= lim) | (p1 < -lim);
    kpt  = p1[N-1+Q:Q];
    p2   = sx(s) * sx(ki);
    of   = of | (p2 >= lim) | (p2 < -lim);
    kit  = p2[N-1+Q:Q];
    i_f  = sx(kit) + sx(ip);
    of   = of | !fits_n(i_f);
    inew = i_f[N-1:0];
    y_f  = sx(kpt) + sx(inew);
    of   = of | !fits_n(y_f);
    y    = y_f[N-1:0];
  endfunction

  int            cyc = 0;
  logic          cap_reset, cap_we;
  logic [CH-1:0] cap_req;
  logic [CH*N-1:0] cap_data;
  logic [CW-1:0] cap_ch;
  logic [1:0]    cap_sel;
  logic [N-1:0]  cap_cd;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    cap_reset <= reset;
    cap_req   <= req;
    cap_data  <= req_data;
    cap_we    <= cfg_we;
    cap_ch    <= cfg_ch;
    cap_sel   <= cfg_sel;
    cap_cd    <= cfg_data;
  end

  logic [N-1:0]  m_kp [CH];
  logic [N-1:0]  m_ki [CH];
  logic [N-1:0]  m_pin[CH];
  logic [N-1:0]  m_pki[CH];
  int            m_ptr, last_grant, pend_due, pend_ch;
  bit            pend_v;
  logic [N-1:0]  pend_x, pend_y, pend_i;
  logic          pend_of;
  logic [CH-1:0] e_ack;
  logic          e_valid, e_of, e_busy;
  logic [CW-1:0] e_ch;
  logic [N-1:0]  e_data;

  always @(negedge clk) begin : model_p
    int c;
    if (cyc > 0) begin
      e_ack   = '0;
      e_valid = 1'b0;
      if (cap_reset) begin
        for (int k = 0; k < CH; k++) begin
          m_kp[k] = KP_INIT; m_ki[k] = KI_INIT; m_pin[k] = '0; m_pki[k] = '0;
        end
        m_ptr = 0; last_grant = -100; pend_v = 1'b0;
        e_ch = '0; e_data = '0; e_of = 1'b0;
      end else begin
        if (pend_v && cyc == pend_due) begin
          m_pin[pend_ch] = pend_x;
          m_pki[pend_ch] = pend_i;
          e_valid = 1'b1; e_ch = CW'(pend_ch); e_data = pend_y; e_of = pend_of;
          pend_v = 1'b0;
        end
        if (cyc >= last_grant + 5 && cap_req != '0) begin
          c = -1;
          for (int k = 0; k < CH; k++)
            if (c < 0 && cap_req[(m_ptr + k) % CH]) c = (m_ptr + k) % CH;
          pend_x = cap_data[c*N +: N];
          pi_eval(pend_x, m_kp[c], m_ki[c], m_pin[c], m_pki[c], pend_y, pend_i, pend_of);
          pend_ch = c; pend_due = cyc + 4; pend_v = 1'b1; last_grant = cyc;
          e_ack[c] = 1'b1;
          m_ptr = (c + 1) % CH;
        end
        if (cap_we) begin
          case (cap_sel)
            2'd0: m_kp[cap_ch] = cap_cd;
            2'd1: m_ki[cap_ch] = cap_cd;
            2'd2: begin m_pin[cap_ch] = '0; m_pki[cap_ch] = '0; end
            default: ;
          endcase
        end
      end
      e_busy = (cyc - last_grant) <= 3;
      check("ack", ack, e_ack);
      check("busy", busy, e_busy);
      check("out_valid", out_valid, e_valid);
      check("out_ch", out_ch, e_ch);
      check("out_data", out_data, e_data);
      check("out_of", out_of, e_of);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cfg_write(input int ch, input logic [1:0] sel, input logic [N-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_sel = sel; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_sample(input int ch, input logic [N-1:0] x, input bit kp_wr,
                            input logic [N-1:0] kp_new, output logic [N-1:0] y,
                            output logic of, output int lat);
    bit got = 1'b0;
    y = '0; of = 1'b0; lat = 0;
    @(negedge clk);
    req[ch] = 1'b1;
    req_data[ch*N +: N] = x;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack[ch]) got = 1'b1;
    end
    req[ch] = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: ch %0d got no ack, expected one within 20 cycles", ch);
      return;
    end
    if (kp_wr) begin
      cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_sel = 2'd0; cfg_data = kp_new;
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      lat++;
      if (out_valid) got = 1'b1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL out_timeout: ch %0d got no out_valid, expected one within 10 cycles", ch);
    end else begin
      y = out_data; of = out_of;
    end
  endtask

  logic [N-1:0] y;
  logic         of;
  int           lat;
  int           rr_exp [5] = '{0, 1, 2, 3, 0};
  int           rr_ch  [5];
  int           rr_t   [5];
  int           rr_n;
  bit           got, seen;

  initial begin
    reset = 1'b1; req = '0; req_data = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_sel = 2'd0; cfg_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // ch0: Kp=1.0, Ki=0.5, two samples of 1.0
    cfg_write(0, 2'd0, 32'h0004_0000);
    cfg_write(0, 2'd1, 32'h0002_0000);
    run_sample(0, 32'h0004_0000, 1'b0, '0, y, of, lat);
    check("ch0_s1_data", y, 32'h0006_0000);
    check("ch0_s1_of", of, 1'b0);
    check("ch0_s1_latency", lat, 4);
    run_sample(0, 32'h0004_0000, 1'b0, '0, y, of, lat);
    check("ch0_s2_data", y, 32'h000A_0000);
    check("ch0_s2_latency", lat, 4);

    // clear ch0 history, then repeat; an ignored cfg_sel=3 write in between
    cfg_write(0, 2'd2, 32'hDEAD_BEEF);
    cfg_write(0, 2'd3, 32'h1234_5678);
    run_sample(0, 32'h0004_0000, 1'b0, '0, y, of, lat);
    check("ch0_after_clear", y, 32'h0006_0000);

    // ch1 product overflow: Kp=4.0, x=0x40000000
    cfg_write(1, 2'd0, 32'h0010_0000);
    run_sample(1, 32'h4000_0000, 1'b0, '0, y, of, lat);
    check("ch1_ovf_data", y, 32'h0000_0000);
    check("ch1_ovf_flag", of, 1'b1);

    // ch3: Kp rewritten to 2.0 while its sample is in SUM
    run_sample(3, 32'h0004_0000, 1'b1, 32'h0008_0000, y, of, lat);
    check("ch3_old_kp", y, 32'h0004_0000);
    run_sample(3, 32'h0004_0000, 1'b0, '0, y, of, lat);
    check("ch3_new_kp", y, 32'h0008_0000);

    // all channels requesting continuously with x=0
    @(negedge clk);
    req = 4'b1111; req_data = '0; rr_n = 0;
    for (int i = 0; i < 60 && rr_n < 5; i++) begin
      @(negedge clk);
      if (ack != 4'b0000) begin
        for (int k = 0; k < CH; k++) if (ack[k]) rr_ch[rr_n] = k;
        rr_t[rr_n] = i;
        rr_n++;
        if (rr_n == 5) req = 4'b0000;
      end
    end
    req = 4'b0000;
    check("rr_ack_count", rr_n, 5);
    for (int k = 0; k < 5; k++) check("rr_order", rr_ch[k], rr_exp[k]);
    for (int k = 1; k < 5; k++) check("rr_spacing", rr_t[k] - rr_t[k-1], 5);
    repeat (6) @(negedge clk);

    // reset while ch2 sample is in KI
    @(negedge clk);
    req[2] = 1'b1; req_data[2*N +: N] = 32'h0004_0000;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack[2]) got = 1'b1;
    end
    req[2] = 1'b0;
    check("ch2_granted", got, 1'b1);
    @(negedge clk);
    check("busy_in_ki", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("busy_after_reset", busy, 1'b0);
    check("valid_after_reset", out_valid, 1'b0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_out_after_abort", seen, 1'b0);
    run_sample(2, 32'h0004_0000, 1'b0, '0, y, of, lat);
    check("ch2_after_reset", y, 32'h0004_0000);
    check("ch2_after_reset_of", of, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
